// File: rtl/count_add.sv
// Run/hold/finish counter with terminal compare against a live PD and a
// saturating wrap counter for auto-reload mode.
module count_add (
    input  logic       CLK,
    input  logic       CLRn,
    input  logic       E,
    input  logic       START,
    input  logic       STOP,
    input  logic       MODE,
    input  logic [5:0] PD,
    output logic [5:0] QT,
    output logic       RCO,
    output logic       BUSY,
    output logic       DONE,
    output logic [3:0] WRAPS
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD, FIN} state_t;

    state_t     state, state_nxt;
    logic [5:0] qt_nxt;
    logic [3:0] wraps_nxt;
    logic       term;

    // STOP outranks everything, so a terminal event never coincides with a pause
    assign term = (state == RUN) & E & ~STOP & (QT == PD);

    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            state <= IDLE;
            QT    <= '0;
            WRAPS <= '0;
        end else begin
            state <= state_nxt;
            QT    <= qt_nxt;
            WRAPS <= wraps_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        qt_nxt    = QT;
        wraps_nxt = WRAPS;
        unique case (state)
            IDLE: begin
                qt_nxt    = '0;
                wraps_nxt = '0;
                if (START && !STOP) state_nxt = RUN;
            end
            RUN: begin
                if (STOP) begin
                    state_nxt = HOLD;
                end else if (term) begin
                    if (MODE) begin
                        qt_nxt = '0;
                        if (WRAPS != 4'hf) wraps_nxt = WRAPS + 4'd1;
                    end else begin
                        state_nxt = FIN;
                    end
                end else if (E) begin
                    qt_nxt = QT + 6'd1;
                end
            end
            HOLD: begin
                if (STOP) begin
                    state_nxt = IDLE;
                    qt_nxt    = '0;
                    wraps_nxt = '0;
                end else if (START) begin
                    state_nxt = RUN;
                end
            end
            FIN: begin
                if (STOP || START) begin
                    state_nxt = STOP ? IDLE : RUN;
                    qt_nxt    = '0;
                    wraps_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state == RUN);
        DONE = (state == FIN);
        RCO  = term;
    end

endmodule
